// File: rtl/speed_report_tx.sv
// Formats each done-captured speed as five ASCII digits + CR LF over a UART line; start bit leaves 16 cycles after done (width 14).
// No flow control: done while busy is dropped with an overrun pulse. Define SPEED_TX_PARITY_EN for an even-parity bit per frame.
module speed_report_tx #(
  parameter int SYS_FREQ    = 50000000,
  parameter int BAUD        = 9600,
  parameter int WIDTH_SPEED = 14
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic                   done,
  output logic                   serial_data_out,
  output logic                   busy,
  output logic                   overrun
);

  localparam int BIT_TICKS = SYS_FREQ / BAUD;
  localparam int TW        = $clog2(BIT_TICKS + 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(BIT_TICKS - 1);
  localparam logic [4:0]    CONV_LAST   = 5'(WIDTH_SPEED - 1);
`ifdef SPEED_TX_PARITY_EN
  localparam logic [3:0]    FRAME_BITS  = 4'd11;
`else
  localparam logic [3:0]    FRAME_BITS  = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WIDTH_SPEED-1:0] r_bin;
  logic [19:0]            r_bcd;
  logic [19:0]            w_adj;
  logic [4:0]             r_conv_cnt;
  logic [TW-1:0]          r_tick;
  logic [3:0]             r_bit;
  logic [2:0]             r_byte;
  logic [7:0]             w_data;
  logic [2:0]             w_bidx;
  logic                   w_bit_val;
  logic                   w_last;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_overrun;

  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [3:0] d;
    dd_adjust = b;
    for (int i = 0; i < 5; i++) begin
      d = b[4*i +: 4];
      dd_adjust[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
  endfunction

  assign w_adj  = dd_adjust(r_bcd);
  assign w_bidx = 3'(r_bit - 4'd1);
  // r_bit == FRAME_BITS means the previous frame's stop bit has just completed.
  assign w_last = (r_state == SEND) && (r_tick == '0) && (r_bit == FRAME_BITS) && (r_byte == 3'd6);

  always_comb begin
    w_data = 8'h0A;
    case (r_byte)
      3'd0:    w_data = {4'h3, r_bcd[19:16]};
      3'd1:    w_data = {4'h3, r_bcd[15:12]};
      3'd2:    w_data = {4'h3, r_bcd[11:8]};
      3'd3:    w_data = {4'h3, r_bcd[7:4]};
      3'd4:    w_data = {4'h3, r_bcd[3:0]};
      3'd5:    w_data = 8'h0D;
      default: w_data = 8'h0A;
    endcase
  end

  always_comb begin
    w_bit_val = 1'b1;
    if (r_bit == 4'd0)
      w_bit_val = 1'b0;
    else if (r_bit <= 4'd8)
      w_bit_val = w_data[w_bidx];
`ifdef SPEED_TX_PARITY_EN
    else if (r_bit == 4'd9)
      w_bit_val = ^w_data;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (done) w_next = CONV;
      CONV:    if (r_conv_cnt == CONV_LAST) w_next = SEND;
      SEND:    if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_conv_cnt <= '0;
      r_tick     <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= done && (r_state != IDLE);
      r_busy    <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (done) begin
            r_bin      <= speed;
            r_bcd      <= '0;
            r_conv_cnt <= '0;
          end
        end
        CONV: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_conv_cnt     <= r_conv_cnt + 5'd1;
          // One spare cycle before the first start bit keeps the byte mux settled.
          if (r_conv_cnt == CONV_LAST) begin
            r_tick <= TW'(1);
            r_bit  <= 4'd0;
            r_byte <= 3'd0;
          end
        end
        SEND: begin
          if (r_tick != '0) begin
            r_tick <= r_tick - TW'(1);
          end else begin
            r_tick <= TICK_RELOAD;
            if (r_bit == FRAME_BITS) begin
              if (r_byte == 3'd6) begin
                r_tx <= 1'b1;
              end else begin
                r_byte <= r_byte + 3'd1;
                r_tx   <= 1'b0;
                r_bit  <= 4'd1;
              end
            end else begin
              r_tx  <= w_bit_val;
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign serial_data_out = r_tx;
  assign busy            = r_busy;
  assign overrun         = r_overrun;

endmodule
